// File: rtl/writeback_issue_unit_if.sv
// Result-packet handshake into the write-back issue stage.
// Master offers packets, slave accepts them with in_ready.
interface writeback_issue_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dest;
    logic [31:0] in_data;
    logic        in_flag_we;
    logic [31:0] in_flag_data;

    modport master (
        output in_valid, in_dest, in_data, in_flag_we, in_flag_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_dest, in_data, in_flag_we, in_flag_data,
        output in_ready
    );
endinterface

// File: rtl/writeback_issue_unit.sv
// In-order result FIFO driving register write-back strobes.
// Head commits when not blocked by an interrupt entry or a flush.
module writeback_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      all_rst_n,
    writeback_issue_unit_if.slave     pkt,
    input  logic                      interrupt_ask,
    input  logic                      pipe_flush,
    output logic [12:0]               back_ask,
    output logic [31:0]               back_value,
    output logic [31:0]               back_flag,
    output logic [12:0]               busy_mask,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      err_bad_dest
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    dest_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic          fwe_q   [DEPTH];
    logic [31:0]   fdata_q [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [AW-1:0] idx;

    logic head_valid;
    logic present;
    logic push;

    // Strobe bits for one entry: its register (1..13) plus flag when flag_we.
    function automatic logic [12:0] dest_bits(input logic [3:0] d, input logic f);
        logic [12:0] m;
        m = '0;
        if (d >= 4'd1 && d <= 4'd13) m = 13'd1 << (d - 4'd1);
        if (f) m[8] = 1'b1;
        return m;
    endfunction

    assign head_valid   = (count != '0);
    assign present      = head_valid & ~interrupt_ask & ~pipe_flush;
    assign pkt.in_ready = (count != CW'(DEPTH));
    assign push         = pkt.in_valid & pkt.in_ready;
    assign fifo_count   = count;

    // Head entry drives the write-back port; strobes only when committing.
    always_comb begin
        back_ask   = '0;
        back_value = '0;
        back_flag  = '0;
        if (head_valid) begin
            back_value = data_q[head];
            back_flag  = (dest_q[head] == 4'd9) ? data_q[head] : fdata_q[head];
        end
        if (present) back_ask = dest_bits(dest_q[head], fwe_q[head]);
    end

    // Pending destinations of every buffered entry, for decode stalls.
    always_comb begin
        busy_mask = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (CW'(k) < count) busy_mask = busy_mask | dest_bits(dest_q[idx], fwe_q[idx]);
        end
    end

    // Payload storage; needs no reset since validity lives in count.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail]  <= pkt.in_dest;
            data_q[tail]  <= pkt.in_data;
            fwe_q[tail]   <= pkt.in_flag_we;
            fdata_q[tail] <= pkt.in_flag_data;
        end
    end

    // Pointer, occupancy and sticky error bookkeeping.
    always_ff @(posedge clk or negedge all_rst_n) begin
        if (!all_rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            err_bad_dest <= 1'b0;
        end else if (pipe_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (present) begin
                head <= head + 1'b1;
                if (dest_q[head] >= 4'd14) err_bad_dest <= 1'b1;
            end
            if (push && !present)      count <= count + 1'b1;
            else if (!push && present) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_issue_unit.sv
// Randomized bench for writeback_issue_unit against a queue model.
// Directed cases pin the model with hand-computed values.
module tb_writeback_issue_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
        logic        fwe;
        logic [31:0] fdata;
    } pkt_t;

    logic        clk;
    logic        all_rst_n;
    logic        interrupt_ask;
    logic        pipe_flush;
    logic [12:0] back_ask;
    logic [31:0] back_value;
    logic [31:0] back_flag;
    logic [12:0] busy_mask;
    logic [2:0]  fifo_count;
    logic        err_bad_dest;

    writeback_issue_unit_if bus ();

    writeback_issue_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .all_rst_n    (all_rst_n),
        .pkt          (bus.slave),
        .interrupt_ask(interrupt_ask),
        .pipe_flush   (pipe_flush),
        .back_ask     (back_ask),
        .back_value   (back_value),
        .back_flag    (back_flag),
        .busy_mask    (busy_mask),
        .fifo_count   (fifo_count),
        .err_bad_dest (err_bad_dest)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    pkt_t q[$];
    logic m_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [12:0] pkt_mask(input pkt_t p);
        logic [12:0] m;
        m = '0;
        if (p.dest >= 4'd1 && p.dest <= 4'd13) m = m | (13'd1 << (p.dest - 4'd1));
        if (p.fwe) m = m | 13'h100;
        return m;
    endfunction

    // Model check on every falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        int          sz;
        logic        present;
        logic        ready;
        logic [12:0] e_ask;
        logic [12:0] e_busy;
        logic [31:0] e_val;
        logic [31:0] e_flag;
        pkt_t        np;
        if (!all_rst_n) begin
            q.delete();
            m_err = 1'b0;
        end
        sz      = q.size();
        ready   = (sz != DEPTH);
        present = (sz > 0) && !interrupt_ask && !pipe_flush;
        e_ask   = '0;
        e_val   = '0;
        e_flag  = '0;
        e_busy  = '0;
        if (sz > 0) begin
            e_val  = q[0].data;
            e_flag = (q[0].dest == 4'd9) ? q[0].data : q[0].fdata;
            if (present) e_ask = pkt_mask(q[0]);
        end
        foreach (q[i]) e_busy = e_busy | pkt_mask(q[i]);
        chk("m_in_ready",   32'(bus.in_ready), 32'(ready));
        chk("m_back_ask",   32'(back_ask),     32'(e_ask));
        chk("m_back_value", back_value,        e_val);
        chk("m_back_flag",  back_flag,         e_flag);
        chk("m_busy_mask",  32'(busy_mask),    32'(e_busy));
        chk("m_fifo_count", 32'(fifo_count),   32'(sz));
        chk("m_err",        32'(err_bad_dest), 32'(m_err));
        if (all_rst_n) begin
            if (pipe_flush) begin
                q.delete();
            end else begin
                if (present) begin
                    if (q[0].dest >= 4'd14) m_err = 1'b1;
                    void'(q.pop_front());
                end
                if (bus.in_valid && ready) begin
                    np.dest  = bus.in_dest;
                    np.data  = bus.in_data;
                    np.fwe   = bus.in_flag_we;
                    np.fdata = bus.in_flag_data;
                    q.push_back(np);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [31:0] dat,
                         input logic fwe, input logic [31:0] fd);
        bus.in_valid     = v;
        bus.in_dest      = d;
        bus.in_data      = dat;
        bus.in_flag_we   = fwe;
        bus.in_flag_data = fd;
    endtask

    initial begin
        all_rst_n     = 1'b0;
        interrupt_ask = 1'b0;
        pipe_flush    = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        cyc();
        cyc();
        chk("rst_back_ask", 32'(back_ask), 32'd0);
        chk("rst_count",    32'(fifo_count), 32'd0);
        chk("rst_ready",    32'(bus.in_ready), 32'd1);
        all_rst_n = 1'b1;
        cyc();

        // single packet
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("single_ask",   32'(back_ask), 32'h004);
        chk("single_value", back_value, 32'hDEADBEEF);
        chk("single_busy",  32'(busy_mask), 32'h004);
        cyc();
        chk("single_busy_clr", 32'(busy_mask), 32'h000);
        chk("single_count",    32'(fifo_count), 32'd0);

        // flag strobes
        drive(1'b1, 4'd1, 32'd5, 1'b1, 32'h2);
        cyc();
        drive(1'b1, 4'd9, 32'd7, 1'b1, 32'd8);
        #1;
        chk("flag_ask",  32'(back_ask), 32'h101);
        chk("flag_data", back_flag, 32'h2);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("flag9_ask",  32'(back_ask), 32'h100);
        chk("flag9_data", back_flag, 32'd7);
        cyc();

        // full under interrupt, then drain
        interrupt_ask = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 32'(100 + i), 1'b0, 32'd0);
            cyc();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ask",   32'(back_ask), 32'd0);
        chk("full_busy",  32'(busy_mask), 32'h00F);
        interrupt_ask = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_ask",   32'(back_ask), 32'(13'd1 << i));
            chk("drain_value", back_value, 32'(100 + i));
            if (i == 1) chk("drain_ready", 32'(bus.in_ready), 32'd1);
            cyc();
        end
        chk("drain_count", 32'(fifo_count), 32'd0);

        // flush with same-cycle enqueue
        interrupt_ask = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd5, 32'(i), 1'b0, 32'd0);
            cyc();
        end
        interrupt_ask = 1'b0;
        pipe_flush    = 1'b1;
        drive(1'b1, 4'd6, 32'd9, 1'b0, 32'd0);
        #1;
        chk("flush_ask",   32'(back_ask), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd3);
        cyc();
        pipe_flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("flush_empty", 32'(fifo_count), 32'd0);
        chk("flush_busy",  32'(busy_mask), 32'd0);

        // illegal destination
        drive(1'b1, 4'd15, 32'd1, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("bad_ask",     32'(back_ask), 32'd0);
        chk("bad_err_pre", 32'(err_bad_dest), 32'd0);
        cyc();
        chk("bad_err",   32'(err_bad_dest), 32'd1);
        chk("bad_count", 32'(fifo_count), 32'd0);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom);
            interrupt_ask = ($urandom_range(0, 9) == 0);
            pipe_flush    = ($urandom_range(0, 39) == 0);
            cyc();
        end

        // reset in the middle of traffic
        pipe_flush    = 1'b0;
        interrupt_ask = 1'b1;
        drive(1'b1, 4'd2, 32'd11, 1'b0, 32'd0);
        cyc();
        cyc();
        all_rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_ask",   32'(back_ask), 32'd0);
        chk("mrst_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst_err",   32'(err_bad_dest), 32'd0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        interrupt_ask = 1'b0;
        cyc();
        cyc();
        all_rst_n = 1'b1;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
